mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between the fetch port and the load/store port.
- Data accesses win by default. A starvation counter forces a fetch grant after STARVE_LIMIT consecutive denied fetches.
- Sits between the fetch/memory pipeline stages and the unified memory array. Drives the fetch stall and the data-stage stall.
- The memory has synchronous read with 1-cycle latency. The arbiter tags each issued access and routes the returned data to the correct requester.

---
 rtl/mem_port_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported, synchronous-read (1-cycle latency) unified memory
// between the instruction-fetch port and the load/store port.
//
//   * Data accesses win a conflict by default (state DATA_PRI).
//   * A starvation counter tracks consecutive denied fetches; once it reaches
//     STARVE_LIMIT the arbiter moves to FETCH_PRI and the next conflict goes to
//     fetch, after which priority returns to data.
//   * Every issued read is tagged so the returned word is steered to the port
//     that asked for it one cycle later.
//
// Optional feature: define ARB_PERF_CNT_EN to add three 32-bit performance
// counters (conflict cycles, fetch-stall cycles, forced fetch grants).
//
// Ports
//   CLK, RST                 clock (rising edge), synchronous active-high reset
//   I_Req, I_Addr            fetch request and word-aligned byte address
//   D_Req, D_W_En            load/store request, 1 = store
//   D_Control, D_Addr        size/sign (funct3), data byte address
//   D_W_Data                 store data
//   M_En, M_W_En, M_Control  memory enable, write enable, size control
//   M_Addr, M_W_Data         memory address and write data
//   M_R_Data                 memory read data (1 cycle after a read)
//   I_Grant, D_Grant         port accepted this cycle
//   Stall_F, Stall_M         request present but not granted
//   I_Valid, I_Data          fetched word returned
//   D_Valid, D_Data          load word returned
//   Perf_*                   performance counters (ARB_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        I_Req,
    input  logic [31:0] I_Addr,
    input  logic        D_Req,
    input  logic        D_W_En,
    input  logic [2:0]  D_Control,
    input  logic [31:0] D_Addr,
    input  logic [31:0] D_W_Data,
    output logic        M_En,
    output logic        M_W_En,
    output logic [2:0]  M_Control,
    output logic [31:0] M_Addr,
    output logic [31:0] M_W_Data,
    input  logic [31:0] M_R_Data,
    output logic        I_Grant,
    output logic        D_Grant,
    output logic        Stall_F,
    output logic        Stall_M,
    output logic        I_Valid,
    output logic [31:0] I_Data,
    output logic        D_Valid,
    output logic [31:0] D_Data
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0] Perf_Conflicts,
    output logic [31:0] Perf_I_Stall,
    output logic [31:0] Perf_Forced
`endif
);

    typedef enum logic [0:0] {
        DATA_PRI  = 1'b0,
        FETCH_PRI = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT_C    = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT_M1_C = CNT_W'(STARVE_LIMIT - 1);
    localparam logic [2:0]       WORD_CTRL  = 3'b010;

    state_t           r_state, w_state_next;
    logic [CNT_W-1:0] r_starve_cnt, w_starve_cnt_next;
    logic [1:0]       r_tag;          // {fetch read pending, load pending}
    logic             w_conflict;
    logic             w_i_grant;
    logic             w_d_grant;

    // ------------------------------------------------------------------
    // Grant decision: purely combinational from requests and state.
    // Reset suppresses all grants so nothing reaches memory.
    // ------------------------------------------------------------------
    always_comb begin
        w_conflict = I_Req & D_Req;
        w_i_grant  = 1'b0;
        w_d_grant  = 1'b0;
        if (!RST) begin
            if (w_conflict) begin
                if (r_state == FETCH_PRI) w_i_grant = 1'b1;
                else                      w_d_grant = 1'b1;
            end else begin
                w_i_grant = I_Req;
                w_d_grant = D_Req;
            end
        end
    end

    assign I_Grant = w_i_grant;
    assign D_Grant = w_d_grant;
    assign Stall_F = I_Req & ~w_i_grant;
    assign Stall_M = D_Req & ~w_d_grant;

    // ------------------------------------------------------------------
    // Priority FSM and starvation counter: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next      = r_state;
        w_starve_cnt_next = r_starve_cnt;

        if (w_i_grant) begin
            w_starve_cnt_next = '0;
        end else if (I_Req && (r_starve_cnt != LIMIT_C)) begin
            w_starve_cnt_next = r_starve_cnt + 1'b1;
        end

        case (r_state)
            DATA_PRI: begin
                // The denial that brings the count to the limit hands the
                // next conflict to fetch.
                if (I_Req && !w_i_grant && (r_starve_cnt == LIMIT_M1_C))
                    w_state_next = FETCH_PRI;
            end
            FETCH_PRI: begin
                if (w_i_grant)
                    w_state_next = DATA_PRI;
            end
            default: w_state_next = DATA_PRI;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= DATA_PRI;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_next;
            r_starve_cnt <= w_starve_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Memory-side mux
    // ------------------------------------------------------------------
    always_comb begin
        M_En      = 1'b0;
        M_W_En    = 1'b0;
        M_Control = WORD_CTRL;
        M_Addr    = '0;
        M_W_Data  = '0;
        if (w_i_grant) begin
            M_En   = 1'b1;
            M_Addr = I_Addr;
        end else if (w_d_grant) begin
            M_En      = 1'b1;
            M_W_En    = D_W_En;
            M_Control = D_Control;
            M_Addr    = D_Addr;
            M_W_Data  = D_W_Data;
        end
    end

    // ------------------------------------------------------------------
    // Response tagging. Stores never set the data tag, so they return
    // nothing. Outputs are also gated by RST so a response that would land
    // in a reset cycle is dropped.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) r_tag <= 2'b00;
        else     r_tag <= {w_i_grant, w_d_grant & ~D_W_En};
    end

    assign I_Valid = r_tag[1] & ~RST;
    assign D_Valid = r_tag[0] & ~RST;
    assign I_Data  = I_Valid ? M_R_Data : 32'd0;
    assign D_Data  = D_Valid ? M_R_Data : 32'd0;

`ifdef ARB_PERF_CNT_EN
    // Index 0: conflict cycles, 1: fetch-stall cycles, 2: forced fetch grants.
    // A fetch grant while data is also requesting can only come from
    // FETCH_PRI, so it marks a forced grant.
    logic [2:0] w_perf_inc;
    assign w_perf_inc = {w_i_grant & D_Req, Stall_F, w_conflict};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_perf
            logic [31:0] r_count;
            always_ff @(posedge CLK) begin
                if (RST)                 r_count <= '0;
                else if (w_perf_inc[gi]) r_count <= r_count + 32'd1;
            end
        end
    endgenerate

    assign Perf_Conflicts = g_perf[0].r_count;
    assign Perf_I_Stall   = g_perf[1].r_count;
    assign Perf_Forced    = g_perf[2].r_count;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter (STARVE_LIMIT = 4). A small
// synchronous-read memory model sits on the memory port, preloaded with
// word i = 0xA000_0000 + i. Inputs change 1 ns after the rising edge;
// outputs are sampled 3 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        I_Req;
    logic [31:0] I_Addr;
    logic        D_Req;
    logic        D_W_En;
    logic [2:0]  D_Control;
    logic [31:0] D_Addr;
    logic [31:0] D_W_Data;
    logic        M_En;
    logic        M_W_En;
    logic [2:0]  M_Control;
    logic [31:0] M_Addr;
    logic [31:0] M_W_Data;
    logic [31:0] M_R_Data;
    logic        I_Grant;
    logic        D_Grant;
    logic        Stall_F;
    logic        Stall_M;
    logic        I_Valid;
    logic [31:0] I_Data;
    logic        D_Valid;
    logic [31:0] D_Data;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] Perf_Conflicts;
    logic [31:0] Perf_I_Stall;
    logic [31:0] Perf_Forced;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [256];

    always #5 CLK = ~CLK;

    mem_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .I_Req     (I_Req),
        .I_Addr    (I_Addr),
        .D_Req     (D_Req),
        .D_W_En    (D_W_En),
        .D_Control (D_Control),
        .D_Addr    (D_Addr),
        .D_W_Data  (D_W_Data),
        .M_En      (M_En),
        .M_W_En    (M_W_En),
        .M_Control (M_Control),
        .M_Addr    (M_Addr),
        .M_W_Data  (M_W_Data),
        .M_R_Data  (M_R_Data),
        .I_Grant   (I_Grant),
        .D_Grant   (D_Grant),
        .Stall_F   (Stall_F),
        .Stall_M   (Stall_M),
        .I_Valid   (I_Valid),
        .I_Data    (I_Data),
        .D_Valid   (D_Valid),
        .D_Data    (D_Data)
`ifdef ARB_PERF_CNT_EN
        ,
        .Perf_Conflicts (Perf_Conflicts),
        .Perf_I_Stall   (Perf_I_Stall),
        .Perf_Forced    (Perf_Forced)
`endif
    );

    // Memory model: synchronous read, one cycle latency.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;
        M_R_Data = 32'd0;
    end

    always @(posedge CLK) begin
        if (M_En) begin
            if (M_W_En) mem[M_Addr[9:2]] <= M_W_Data;
            else        M_R_Data <= mem[M_Addr[9:2]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Sampling point inside the current cycle.
    task automatic settle();
        #2;
    endtask

    initial begin
        RST = 1'b1; I_Req = 1'b0; I_Addr = '0; D_Req = 1'b0; D_W_En = 1'b0;
        D_Control = 3'b010; D_Addr = '0; D_W_Data = '0;

        // ---------------- reset behaviour ----------------
        cyc(); cyc();
        I_Req = 1'b1; D_Req = 1'b1;
        settle();
        chk("rst_i_grant", {31'd0, I_Grant}, 32'd0);
        chk("rst_d_grant", {31'd0, D_Grant}, 32'd0);
        chk("rst_m_en",    {31'd0, M_En},    32'd0);
        chk("rst_stall_f", {31'd0, Stall_F}, 32'd1);
        chk("rst_stall_m", {31'd0, Stall_M}, 32'd1);
        chk("rst_valid",   {30'd0, I_Valid, D_Valid}, 32'd0);
        cyc();
        RST = 1'b0; I_Req = 1'b0; D_Req = 1'b0;
        settle();
        chk("idle_m_en",   {31'd0, M_En}, 32'd0);
        chk("idle_m_ctrl", {29'd0, M_Control}, 32'd2);
        chk("idle_m_addr", M_Addr, 32'd0);

        // ---------------- 1: fetch only ----------------
        cyc(); I_Req = 1'b1; I_Addr = 32'h00; settle();
        chk("t1_grant0", {30'd0, I_Grant, Stall_F}, 32'd2);
        chk("t1_addr0",  M_Addr, 32'h00);
        cyc(); I_Addr = 32'h04; settle();
        chk("t1_grant1", {30'd0, I_Grant, Stall_F}, 32'd2);
        chk("t1_data0",  I_Data, 32'hA000_0000);
        cyc(); I_Addr = 32'h08; settle();
        chk("t1_grant2", {30'd0, I_Grant, Stall_F}, 32'd2);
        chk("t1_data1",  I_Data, 32'hA000_0001);
        cyc(); I_Req = 1'b0; settle();
        chk("t1_valid2", {31'd0, I_Valid}, 32'd1);
        chk("t1_data2",  I_Data, 32'hA000_0002);

        // ---------------- 2: load beats fetch ----------------
        cyc(); I_Req = 1'b1; I_Addr = 32'h10; D_Req = 1'b1; D_W_En = 1'b0;
        D_Addr = 32'h40; D_Control = 3'b010; settle();
        chk("t2_grants", {29'd0, I_Grant, D_Grant, Stall_F}, 32'b011);
        chk("t2_addr",   M_Addr, 32'h40);
        cyc(); D_Req = 1'b0; settle();
        chk("t2_d_valid", {30'd0, I_Valid, D_Valid}, 32'b01);
        chk("t2_d_data",  D_Data, 32'hA000_0010);
        chk("t2_i_grant", {31'd0, I_Grant}, 32'd1);
        cyc(); I_Req = 1'b0; settle();
        chk("t2_i_valid", {30'd0, I_Valid, D_Valid}, 32'b10);
        chk("t2_i_data",  I_Data, 32'hA000_0004);

        // ---------------- 3: store then load ----------------
        cyc(); D_Req = 1'b1; D_W_En = 1'b1; D_Addr = 32'h80;
        D_W_Data = 32'hDEAD_BEEF; D_Control = 3'b010; settle();
        chk("t3_st_wen",  {30'd0, M_En, M_W_En}, 32'b11);
        chk("t3_st_data", M_W_Data, 32'hDEAD_BEEF);
        cyc(); D_W_En = 1'b0; settle();
        chk("t3_ld_wen",   {30'd0, D_Grant, M_W_En}, 32'b10);
        chk("t3_st_noval", {31'd0, D_Valid}, 32'd0);
        cyc(); D_Req = 1'b0; settle();
        chk("t3_ld_valid", {31'd0, D_Valid}, 32'd1);
        chk("t3_ld_data",  D_Data, 32'hDEAD_BEEF);

        // ---------------- 4: starvation (also perf scenario) ----------------
        cyc(); RST = 1'b1;
        cyc(); RST = 1'b0;
        for (int k = 0; k < 10; k++) begin
            I_Req = 1'b1; I_Addr = 32'h10; D_Req = 1'b1; D_W_En = 1'b0; D_Addr = 32'h40;
            settle();
            chk($sformatf("t4_c%0d_grants", k), {29'd0, I_Grant, D_Grant, Stall_M},
                (k == 4 || k == 9) ? 32'b101 : 32'b010);
            chk($sformatf("t4_c%0d_i_valid", k), {31'd0, I_Valid}, (k == 5) ? 32'd1 : 32'd0);
            cyc();
        end
        I_Req = 1'b0; D_Req = 1'b0; settle();
`ifdef ARB_PERF_CNT_EN
        chk("t6_conflicts", Perf_Conflicts, 32'd10);
        chk("t6_forced",    Perf_Forced,    32'd2);
        chk("t6_i_stall",   Perf_I_Stall,   32'd8);
`endif

        // ---------------- 5: reset mid-access ----------------
        // Two denied fetches leave the counter at 2 before the reset.
        cyc(); I_Req = 1'b1; D_Req = 1'b1; D_W_En = 1'b0; D_Addr = 32'h40;
        cyc();
        cyc(); I_Req = 1'b0; settle();
        chk("t5_ld_grant", {31'd0, D_Grant}, 32'd1);
        cyc(); D_Req = 1'b0; RST = 1'b1; settle();
        chk("t5_rst_valid", {30'd0, I_Valid, D_Valid}, 32'd0);
        chk("t5_rst_data",  D_Data, 32'd0);
        chk("t5_rst_m_en",  {31'd0, M_En}, 32'd0);
        cyc(); RST = 1'b0; settle();
        chk("t5_post_valid", {30'd0, I_Valid, D_Valid}, 32'd0);
        chk("t5_post_ctrl",  {29'd0, M_Control}, 32'd2);
        chk("t5_post_addr",  M_Addr, 32'd0);
        // Cleared counter and DATA_PRI: four data grants, then fetch.
        for (int k = 0; k < 5; k++) begin
            cyc(); I_Req = 1'b1; D_Req = 1'b1; settle();
            chk($sformatf("t5_c%0d_grants", k), {30'd0, I_Grant, D_Grant},
                (k == 4) ? 32'b10 : 32'b01);
        end
        cyc(); I_Req = 1'b0; D_Req = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
